// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller and its monitor.
// Holds the monitor state enumeration, the fault cause codes and the default
// phase durations. The controller uses the same durations so that both sides
// agree on the timing.
package traffic_light_pkg;

    typedef enum logic [2:0] {
        ST_SYNC   = 3'd0,
        ST_RED    = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_FAULT  = 3'd4
    } tl_state_t;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ENCODING = 3'd1;
    localparam logic [2:0] ERR_SEQUENCE = 3'd2;
    localparam logic [2:0] ERR_EARLY    = 3'd3;
    localparam logic [2:0] ERR_OVERSTAY = 3'd4;

    localparam int unsigned DEF_RED_CYCLES    = 32;
    localparam int unsigned DEF_GREEN_CYCLES  = 20;
    localparam int unsigned DEF_YELLOW_CYCLES = 7;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/traffic_light_dwell_counter.sv
// Dwell counter for the traffic light monitor.
// Counts enabled samples spent in the current phase and flags when the count
// equals the required dwell of that phase.
// Ports:
//   clk       - rising-edge clock
//   clear     - synchronous clear to 0 (highest priority)
//   start     - load 1 (first sample of a new phase)
//   inc       - increment by one
//   target    - required dwell of the current phase
//   count     - current dwell
//   at_target - count equals target
// With none of clear/start/inc asserted the count holds.
module traffic_light_dwell_counter #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic             inc,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] count,
    output logic             at_target
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (start) begin
            count <= WIDTH'(1);
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_target = (count == target);

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light monitor.
// Watches the light outputs of a controller on every enabled cycle and checks
// one-hot encoding, the RED->GREEN->YELLOW->RED order and the dwell of each
// phase. The first fault is latched until reset.
// Ports:
//   clk         - rising-edge clock
//   reset       - synchronous active-high reset
//   enable      - controller enable; lights are only sampled when 1
//   red/yellow/green - observed lights
//   phase_done  - one-cycle pulse after each legal, correctly timed change
//   error       - sticky fault flag
//   err_code    - first fault cause (0 none, 1 encoding, 2 sequence,
//                 3 early, 4 overstay)
//   cycle_count - completed light cycles, saturating
module traffic_light_monitor #(
    parameter int unsigned RED_CYCLES    = traffic_light_pkg::DEF_RED_CYCLES,
    parameter int unsigned GREEN_CYCLES  = traffic_light_pkg::DEF_GREEN_CYCLES,
    parameter int unsigned YELLOW_CYCLES = traffic_light_pkg::DEF_YELLOW_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        red,
    input  logic        yellow,
    input  logic        green,
    output logic        phase_done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [15:0] cycle_count
);

    import traffic_light_pkg::*;

    localparam int unsigned MAX_CYCLES = max3(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES);
    localparam int unsigned DW         = $clog2(MAX_CYCLES + 2);

    localparam logic [DW-1:0] RED_T    = DW'(RED_CYCLES);
    localparam logic [DW-1:0] GREEN_T  = DW'(GREEN_CYCLES);
    localparam logic [DW-1:0] YELLOW_T = DW'(YELLOW_CYCLES);

    tl_state_t     state;
    tl_state_t     next_state;

    logic [DW-1:0] dwell;
    logic [DW-1:0] dwell_target;
    logic          dwell_full;
    logic          cnt_start;
    logic          cnt_inc;

    logic          fault_hit;
    logic [2:0]    fault_code;
    logic          pulse;
    logic          cycle_inc;
    logic          one_hot;

    assign one_hot = ({1'b0, red} + {1'b0, yellow} + {1'b0, green}) == 2'd1;

    always_comb begin
        dwell_target = '0;
        case (state)
            ST_RED:    dwell_target = RED_T;
            ST_GREEN:  dwell_target = GREEN_T;
            ST_YELLOW: dwell_target = YELLOW_T;
            default:   dwell_target = '0;
        endcase
    end

    traffic_light_dwell_counter #(
        .WIDTH (DW)
    ) u_dwell (
        .clk       (clk),
        .clear     (reset),
        .start     (cnt_start),
        .inc       (cnt_inc),
        .target    (dwell_target),
        .count     (dwell),
        .at_target (dwell_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_SYNC;
        end else begin
            state <= next_state;
        end
    end

    // Since overstay is caught at dwell == target, dwell never exceeds the
    // target, so "not at target" on a legal change means early.
    always_comb begin
        next_state = state;
        cnt_start  = 1'b0;
        cnt_inc    = 1'b0;
        fault_hit  = 1'b0;
        fault_code = ERR_NONE;
        pulse      = 1'b0;
        cycle_inc  = 1'b0;

        if (enable && (state != ST_FAULT)) begin
            if (!one_hot) begin
                fault_hit  = 1'b1;
                fault_code = ERR_ENCODING;
            end else begin
                case (state)
                    ST_SYNC: begin
                        if (red) begin
                            next_state = ST_RED;
                            cnt_start  = 1'b1;
                        end else begin
                            fault_hit  = 1'b1;
                            fault_code = ERR_SEQUENCE;
                        end
                    end
                    ST_RED: begin
                        if (red) begin
                            if (dwell_full) begin
                                fault_hit  = 1'b1;
                                fault_code = ERR_OVERSTAY;
                            end else begin
                                cnt_inc = 1'b1;
                            end
                        end else if (green) begin
                            if (dwell_full) begin
                                next_state = ST_GREEN;
                                cnt_start  = 1'b1;
                                pulse      = 1'b1;
                            end else begin
                                fault_hit  = 1'b1;
                                fault_code = ERR_EARLY;
                            end
                        end else begin
                            fault_hit  = 1'b1;
                            fault_code = ERR_SEQUENCE;
                        end
                    end
                    ST_GREEN: begin
                        if (green) begin
                            if (dwell_full) begin
                                fault_hit  = 1'b1;
                                fault_code = ERR_OVERSTAY;
                            end else begin
                                cnt_inc = 1'b1;
                            end
                        end else if (yellow) begin
                            if (dwell_full) begin
                                next_state = ST_YELLOW;
                                cnt_start  = 1'b1;
                                pulse      = 1'b1;
                            end else begin
                                fault_hit  = 1'b1;
                                fault_code = ERR_EARLY;
                            end
                        end else begin
                            fault_hit  = 1'b1;
                            fault_code = ERR_SEQUENCE;
                        end
                    end
                    ST_YELLOW: begin
                        if (yellow) begin
                            if (dwell_full) begin
                                fault_hit  = 1'b1;
                                fault_code = ERR_OVERSTAY;
                            end else begin
                                cnt_inc = 1'b1;
                            end
                        end else if (red) begin
                            if (dwell_full) begin
                                next_state = ST_RED;
                                cnt_start  = 1'b1;
                                pulse      = 1'b1;
                                cycle_inc  = 1'b1;
                            end else begin
                                fault_hit  = 1'b1;
                                fault_code = ERR_EARLY;
                            end
                        end else begin
                            fault_hit  = 1'b1;
                            fault_code = ERR_SEQUENCE;
                        end
                    end
                    default: begin
                        next_state = state;
                    end
                endcase
            end

            if (fault_hit) begin
                next_state = ST_FAULT;
                cnt_start  = 1'b0;
                cnt_inc    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_done  <= 1'b0;
            error       <= 1'b0;
            err_code    <= ERR_NONE;
            cycle_count <= '0;
        end else begin
            phase_done <= pulse;
            if (fault_hit) begin
                error <= 1'b1;
                if (!error) begin
                    err_code <= fault_code;
                end
            end
            if (cycle_inc && (cycle_count != 16'hFFFF)) begin
                cycle_count <= cycle_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 SHALL have parameter RED_CYCLES, default 32, required red dwell in enabled cycles.
REQ-002 SHALL have parameter GREEN_CYCLES, default 20, required green dwell in enabled cycles.
REQ-003 SHALL have parameter YELLOW_CYCLES, default 7, required yellow dwell in enabled cycles.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  same enable that drives the light controller; 0 = controller frozen.
REQ-007 SHALL have ports red, yellow, green  input  1 each  observed light outputs of the controller.
REQ-008 SHALL have port phase_done  output  1  one-cycle pulse on each legal, correctly timed phase change.
REQ-009 SHALL have port error  output  1  sticky fault flag.
REQ-010 SHALL have port err_code  output  3  first fault cause: 0 none, 1 ENCODING, 2 SEQUENCE, 3 EARLY, 4 OVERSTAY.
REQ-011 SHALL have port cycle_count  output  16  completed red->green->yellow->red cycles, saturating at 16'hFFFF.

Function
REQ-012 SHALL implement states SYNC, RED, GREEN, YELLOW, FAULT.
REQ-013 SHALL sample lights only on enabled cycles (enable=1); on enable=0 SHALL hold state, dwell counter and outputs, and perform no checks; phase_done SHALL be 0.
REQ-014 SHALL flag ENCODING when an enabled sample is not exactly one-hot (none lit or more than one lit).
REQ-015 In SYNC, a red-only sample SHALL enter RED with dwell=1; a green-only or yellow-only sample SHALL flag SEQUENCE.
REQ-016 In a phase state, a sample of the same light SHALL increment dwell; if dwell already equals that phase's required count, OVERSTAY SHALL be flagged instead.
REQ-017 Legal order SHALL be RED->GREEN->YELLOW->RED; a change to any other one-hot light SHALL flag SEQUENCE.
REQ-018 A legal change with dwell < required count SHALL flag EARLY.
REQ-019 A legal change with dwell == required count SHALL enter the next state with dwell=1 and pulse phase_done the following cycle.
REQ-020 A legal YELLOW->RED change with correct timing SHALL increment cycle_count, saturating (no wrap).
REQ-021 Priority when several checks apply SHALL be ENCODING > SEQUENCE > EARLY > OVERSTAY.
REQ-022 Any fault SHALL enter FAULT; error=1 and err_code SHALL be registered one cycle after the offending sample.
REQ-023 FAULT SHALL be absorbing until reset; err_code SHALL keep the first cause; cycle_count SHALL freeze; phase_done SHALL stay 0.
REQ-024 Dwell counter width SHALL be sized for max(RED_CYCLES, GREEN_CYCLES, YELLOW_CYCLES)+1.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 reset=1 at a rising edge SHALL force state SYNC, dwell=0, phase_done=0, error=0, err_code=0, cycle_count=0.
REQ-027 reset SHALL override enable and every check, including from FAULT and mid-phase.
REQ-028 The first sample after reset deasserts SHALL be evaluated under SYNC rules.

Structure
REQ-029 A shared package traffic_light_pkg SHALL hold the state enumeration, err_code constants and default phase durations, also used by the light controller.
REQ-030 The dwell counter with its compare logic SHALL be one sub-module, traffic_light_dwell_counter (clear, increment, hold, equals-target output).

Verification
REQ-031 Reset 5 cycles, then drive legal 32/20/7 sequence twice with enable=1 -> no error, 6 phase_done pulses, cycle_count=2.
REQ-032 Red held 33 enabled cycles -> error=1, err_code=4 one cycle after the 33rd sample.
REQ-033 Green for 19 cycles, then yellow -> err_code=3; subsequent legal traffic leaves err_code=3.
REQ-034 Red->yellow change after 32 red cycles -> err_code=2; red+green lit together -> err_code=1.
REQ-035 enable=0 for 10 cycles mid-green, then resume with 20 total green samples -> no error; the dwell excludes frozen cycles.
REQ-036 Fault at any point, then reset 1 cycle -> all outputs 0, state SYNC; the next red sample starts a clean check.
